// File: rtl/seg_scan_driver_if.sv
// Write/commit port and display-pin bundle for seg_scan_driver.
// Optional SEG_BLINK_EN adds the per-digit blink_mask line.
interface seg_scan_driver_if #(
    parameter int DIGITS = 8
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              wr_en;
    logic [IW-1:0]     wr_addr;
    logic [3:0]        wr_data;
    logic              commit;
    logic              commit_pending;
    logic              frame_done;
    logic [7:0]        seg_out;
    logic [DIGITS-1:0] seg_en;
`ifdef SEG_BLINK_EN
    logic [DIGITS-1:0] blink_mask;

    modport master (
        output wr_en, wr_addr, wr_data, commit, blink_mask,
        input  commit_pending, frame_done, seg_out, seg_en
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, commit, blink_mask,
        output commit_pending, frame_done, seg_out, seg_en
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  commit_pending, frame_done, seg_out, seg_en
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output commit_pending, frame_done, seg_out, seg_en
    );
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner with shadow/active buffers and frame-aligned commit.
// Optional feature macro SEG_BLINK_EN adds per-digit blinking driven by a frame counter.
module seg_scan_driver #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
`ifdef SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input logic               clk,
    input logic               rst,
    seg_scan_driver_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t            state;
    logic [3:0]        shadow [DIGITS];
    logic [3:0]        active [DIGITS];
    logic [PW-1:0]     psc;
    logic [IW-1:0]     idx;
    logic              tc_s;
    logic              wrap_s;
    logic              mute_s;
    logic [7:0]        seg_out_r;
    logic [DIGITS-1:0] seg_en_r;
    logic              frame_done_r;
    logic              commit_pending_r;

    function automatic logic [7:0] decode(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'h0:    pat = 8'hFC;
            4'h1:    pat = 8'h60;
            4'h2:    pat = 8'hDA;
            4'h3:    pat = 8'hF2;
            4'h4:    pat = 8'h0A;
            4'h5:    pat = 8'hB6;
            4'h6:    pat = 8'h6E;
            4'h7:    pat = 8'h1C;
            4'hA:    pat = 8'hEE;
            4'hB:    pat = 8'h3E;
            4'hC:    pat = 8'h9C;
            4'hE:    pat = 8'h9E;
            4'hF:    pat = 8'h8E;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    // Slot terminal count and frame wrap decode
    always_comb begin
        tc_s   = (psc == PW'(SCAN_DIV - 1));
        wrap_s = tc_s && (idx == IW'(DIGITS - 1));
    end

    // Prescaler and digit index; free-running, never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
            idx <= '0;
        end else if (tc_s) begin
            psc <= '0;
            idx <= wrap_s ? '0 : idx + IW'(1);
        end else begin
            psc <= psc + PW'(1);
        end
    end

    // Shadow buffer, written only through the write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) shadow[i] <= 4'hD;
        end else if (bus.wr_en) begin
            shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Commit FSM; the whole shadow moves to active on the frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            commit_pending_r <= 1'b0;
            for (int i = 0; i < DIGITS; i++) active[i] <= 4'hD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.commit) begin
                        state            <= PENDING;
                        commit_pending_r <= 1'b1;
                    end
                end
                PENDING: begin
                    if (wrap_s) begin
                        for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
                        state            <= IDLE;
                        commit_pending_r <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    commit_pending_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frame_cnt;
    logic          phase;

    // Blink phase flips after every BLINK_FRAMES frame wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (wrap_s) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Segments of a blinking digit go dark during the off phase
    always_comb begin
        mute_s = phase && bus.blink_mask[idx];
    end
`else
    // Without blinking, segments always follow the decoded code
    always_comb begin
        mute_s = 1'b0;
    end
`endif

    // Registered pin drive; enables stay off for the first BLANK_CYC cycles of a slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out_r    <= 8'h00;
            seg_en_r     <= '0;
            frame_done_r <= 1'b0;
        end else begin
            seg_out_r    <= mute_s ? 8'h00 : decode(active[idx]);
            seg_en_r     <= (int'(psc) < BLANK_CYC) ? '0 : (DIGITS'(1) << idx);
            frame_done_r <= wrap_s;
        end
    end

    assign bus.seg_out        = seg_out_r;
    assign bus.seg_en         = seg_en_r;
    assign bus.frame_done     = frame_done_r;
    assign bus.commit_pending = commit_pending_r;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2).
// Expected pins come from the cycle count k since reset release and the expected active codes.
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   k          = 0;

    logic [3:0] code [8];
    logic [7:0] mask_m;
    logic [7:0] exp_en;
    logic [7:0] exp_so;
    logic       exp_fd;
    int         slot;

    seg_scan_driver_if #(.DIGITS(8)) bus ();

    seg_scan_driver #(
        .DIGITS(8),
        .SCAN_DIV(4),
        .BLANK_CYC(1)
`ifdef SEG_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [3:0] c);
        case (c)
            4'h0: return 8'hFC;
            4'h1: return 8'h60;
            4'h2: return 8'hDA;
            4'h3: return 8'hF2;
            4'h4: return 8'h0A;
            4'h5: return 8'hB6;
            4'h6: return 8'h6E;
            4'h7: return 8'h1C;
            4'hA: return 8'hEE;
            4'hB: return 8'h3E;
            4'hC: return 8'h9C;
            4'hE: return 8'h9E;
            4'hF: return 8'h8E;
            default: return 8'h00;
        endcase
    endfunction

    // One clock: inputs set beforehand are taken at this edge; outputs sampled at the next negedge
    task automatic tick();
        @(posedge clk);
        k = k + 1;
        @(negedge clk);
        slot   = ((k - 1) / 4) % 8;
        exp_en = (((k - 1) % 4) == 0) ? 8'h00 : (8'h01 << slot);
        exp_fd = ((k % 32) == 0);
        exp_so = pat(code[slot]);
`ifdef SEG_BLINK_EN
        if (((((k - 1) / 64) % 2) == 1) && mask_m[slot]) exp_so = 8'h00;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_out: got en=%h seg=%h fd=%b pend=%b want all 0",
                     bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending);
        end
        rst = 1'b0;
        k   = 0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 64; i++) begin
            tick();
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, 1'b0}) begin
                mismatched++;
                $display("FAIL scan k=%0d: got en=%h seg=%h fd=%b pend=%b want en=%h seg=%h fd=%b pend=0",
                         k, bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending, exp_en, exp_so, exp_fd);
            end
        end
    endtask

    task automatic test_commit();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h5;
        tick();
        bus.wr_addr = 3'd3; bus.wr_data = 4'hA;
        tick();
        bus.wr_en = 1'b0; bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 128) begin
            if (k == 96) begin
                code[0] = 4'h5;
                code[3] = 4'hA;
            end
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, (k < 96)}) begin
                mismatched++;
                $display("FAIL commit k=%0d: got en=%h seg=%h fd=%b pend=%b want en=%h seg=%h fd=%b pend=%b",
                         k, bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending, exp_en, exp_so, exp_fd, (k < 96));
            end
            tick();
        end
    endtask

    task automatic test_no_commit();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h1;
        tick();
        bus.wr_en = 1'b0;
        while (k < 224) begin
            tick();
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, 1'b0}) begin
                mismatched++;
                $display("FAIL hold k=%0d: got en=%h seg=%h pend=%b want en=%h seg=%h pend=0",
                         k, bus.seg_en, bus.seg_out, bus.commit_pending, exp_en, exp_so);
            end
        end
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 288) begin
            if (k == 256) code[0] = 4'h1;
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, (k < 256)}) begin
                mismatched++;
                $display("FAIL late_commit k=%0d: got en=%h seg=%h pend=%b want en=%h seg=%h pend=%b",
                         k, bus.seg_en, bus.seg_out, bus.commit_pending, exp_en, exp_so, (k < 256));
            end
            tick();
        end
    endtask

    task automatic test_commit_on_wrap();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 4'h6;
        tick();
        bus.wr_en = 1'b0;
        while (k < 319) tick();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 384) begin
            if (k == 352) code[1] = 4'h6;
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, (k < 352)}) begin
                mismatched++;
                $display("FAIL wrap_commit k=%0d: got en=%h seg=%h fd=%b pend=%b want en=%h seg=%h fd=%b pend=%b",
                         k, bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending, exp_en, exp_so, exp_fd, (k < 352));
            end
            tick();
        end
    endtask

    task automatic test_write_in_transfer();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 4'hC;
        tick();
        bus.wr_en = 1'b0; bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 415) tick();
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 4'h7;
        tick();
        bus.wr_en = 1'b0;
        code[2] = 4'hC;
        while (k < 448) begin
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, 1'b0}) begin
                mismatched++;
                $display("FAIL xfer_write k=%0d: got en=%h seg=%h pend=%b want en=%h seg=%h pend=0",
                         k, bus.seg_en, bus.seg_out, bus.commit_pending, exp_en, exp_so);
            end
            tick();
        end
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 512) begin
            if (k == 480) code[2] = 4'h7;
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, (k < 480)}) begin
                mismatched++;
                $display("FAIL xfer_second k=%0d: got en=%h seg=%h pend=%b want en=%h seg=%h pend=%b",
                         k, bus.seg_en, bus.seg_out, bus.commit_pending, exp_en, exp_so, (k < 480));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_pending();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== 18'h0) begin
            mismatched++;
            $display("FAIL reset_async: got en=%h seg=%h fd=%b pend=%b want all 0",
                     bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 8; i++) code[i] = 4'hD;
        for (int i = 0; i < 64; i++) begin
            tick();
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, 1'b0}) begin
                mismatched++;
                $display("FAIL post_reset k=%0d: got en=%h seg=%h fd=%b pend=%b want en=%h seg=%h fd=%b pend=0",
                         k, bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending, exp_en, exp_so, exp_fd);
            end
        end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        mask_m = 8'h01;
        bus.blink_mask = 8'h01;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h0;
        tick();
        bus.wr_addr = 3'd1; bus.wr_data = 4'h3;
        tick();
        bus.wr_en = 1'b0; bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        while (k < 256) begin
            if (k == 96) begin
                code[0] = 4'h0;
                code[1] = 4'h3;
            end
            compared++;
            if ({bus.seg_en, bus.seg_out, bus.frame_done, bus.commit_pending} !== {exp_en, exp_so, exp_fd, (k < 96)}) begin
                mismatched++;
                $display("FAIL blink k=%0d: got en=%h seg=%h pend=%b want en=%h seg=%h pend=%b",
                         k, bus.seg_en, bus.seg_out, bus.commit_pending, exp_en, exp_so, (k < 96));
            end
            tick();
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 4'h0;
        bus.commit  = 1'b0;
        mask_m      = 8'h00;
`ifdef SEG_BLINK_EN
        bus.blink_mask = 8'h00;
`endif
        for (int i = 0; i < 8; i++) code[i] = 4'hD;
        test_reset();
        test_scan();
        test_commit();
        test_no_commit();
        test_commit_on_wrap();
        test_write_in_transfer();
        test_reset_mid_pending();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the 8-digit 7-segment display bank. Takes 4-bit display codes from the mode/song logic through a write port into a shadow buffer and commits them atomically at frame boundaries. It decodes each active code to a segment pattern and scans one digit enable at a time with anti-ghosting blanking. It sits between the control FSM and the board display pins, and drives the physical display.

## Interface
- `DIGITS`, 8: number of digit positions; the index width is 3.
- `SCAN_DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16: blanked cycles at the start of each slot; must be < `SCAN_DIV`.
- `BLINK_FRAMES`, 64: frames per blink phase. Exists only with `SEG_BLINK_EN`.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `wr_en`, in, 1: write `wr_data` into shadow entry `wr_addr`.
- `wr_addr`, in, 3: shadow digit index.
- `wr_data`, in, 4: display code.
- `commit`, in, 1: request shadow→active transfer at the next frame boundary.
- `commit_pending`, out, 1: high from the cycle after an accepted `commit` until the transfer.
- `frame_done`, out, 1: 1-cycle pulse at each frame wrap.
- `seg_out`, out, 8: segment lines, active-high; bit7 = a … bit1 = g, bit0 = dp.
- `seg_en`, out, 8: one-hot digit enable, active-high.
- `blink_mask`, in, 8: per-digit blink enable. Exists only with `SEG_BLINK_EN`.

## Operation
- Code→pattern map (hex):
  - 0→FC, 1→60, 2→DA, 3→F2 (digits 0–3).
  - 4→0A (R), 5→B6 (S), 6→6E (H), 7→1C (L).
  - A→EE, B→3E, C→9C, E→9E, F→8E.
  - 8, 9 and D→00 (blank).
- Buffers:
  - Shadow and active are each `DIGITS`×4 bits.
  - Only the write port changes shadow.
  - Only a commit transfer changes active.
- Commit FSM has two states:
  - IDLE: `commit` → PENDING (`commit_pending`=1 next cycle).
  - PENDING: at frame wrap, active ← shadow (all digits in one cycle), then → IDLE.
  - `commit` while PENDING is ignored.
- Scan:
  - A prescaler counts 0..`SCAN_DIV`−1.
  - At terminal count, the digit index increments.
  - Wrap is index `DIGITS`−1 → 0, and it asserts `frame_done`.
- Output:
  - `seg_en` = one-hot(index), except it is 00 while prescaler < `BLANK_CYC`.
  - `seg_out` = decode(active[index]).
- Reset values:
  - Shadow and active all = D (blank).
  - Prescaler 0, index 0, FSM IDLE.
  - `seg_out`=00, `seg_en`=00, `commit_pending`=0, `frame_done`=0.
- Reset asserted mid-frame or mid-PENDING aborts immediately; the pending commit is lost.

## Timing
- All outputs are registered, with 1-cycle latency from internal prescaler/index/active state.
- Shadow writes take effect at the clock edge; a write is visible to a later commit.
- `wr_en` with `commit` in the same cycle: the write is included in the eventual transfer.
- `wr_en` in the transfer cycle: active takes the pre-write shadow value; the new value stays in shadow only.
- `commit` in the wrap cycle itself: the FSM is still IDLE at that edge, so the transfer happens at the following wrap.
- `frame_done`, the transfer, and `commit_pending` falling occur on the same edge.
- The new digit content appears on `seg_out` one cycle after the transfer edge; it is blanked if within `BLANK_CYC`.
- Frame period = `DIGITS`×`SCAN_DIV` cycles; the scan never stalls.

## Configuration
- `SEG_BLINK_EN` defined:
  - Adds `blink_mask` and `BLINK_FRAMES`, plus a frame counter and a phase bit.
  - Phase toggles every `BLINK_FRAMES` wraps; both reset to 0.
  - When phase = 1 and `blink_mask[index]` = 1, `seg_out` is forced to 00; `seg_en` is unaffected.
- `SEG_BLINK_EN` undefined: no port, no counter, no blink logic; `seg_out` is always the decoded value.

## Test plan
Bench uses `SCAN_DIV`=4, `BLANK_CYC`=1, `BLINK_FRAMES`=2.
- Reset release, no writes: `seg_out`=00 and `seg_en` walks 01,02,…,80 with 1 blank cycle per slot; `frame_done` pulses every 32 cycles.
- Write digit0=5 and digit3=A, then commit: `commit_pending`=1 until the wrap. After the wrap, `seg_out`=B6 while `seg_en`=01, EE while `seg_en`=08, and 00 otherwise.
- Write digit0=1 without commit for 3 frames: the display is unchanged; a later commit shows 60 on digit0 after the next wrap.
- `commit` in the wrap cycle: no transfer at that wrap; the transfer happens at the next wrap, 32 cycles later.
- Write digit2=7 in the transfer cycle: active digit2 keeps its old value; a second commit then shows 1C.
- `rst` pulse mid-PENDING: all outputs are 00 immediately, `commit_pending`=0, and buffers are blank.
- With `SEG_BLINK_EN` and mask=01, digit0=0: FC shows for 2 frames, then 00 for 2 frames; the other digits are steady.
